// File: rtl/wb_split128to32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_split128to32 (with package wb_split128to32_pkg)            |
// | Description : Sequential splitter for one 128-bit Wishbone request.         |
// |               It issues one classic 32-bit beat for each active 4-bit sel   |
// |               lane, from the lowest lane upwards. For reads it reassembles  |
// |               the returned data into a single 128-bit response. Upstream    |
// |               sees exactly one ack, err or rty for each accepted request.   |
// | Ports       : clk_i     - system clock                                      |
// |               rst_ni    - synchronous active-low reset                      |
// |               req128_i  - upstream 128-bit request                          |
// |               resp128_o - upstream response (ack/err/rty/stall/dat/cid/tid) |
// |               req32_o   - downstream 32-bit request                         |
// |               resp32_i  - downstream response (ack/err/rty/dat)             |
// | Options     : WB_SPLIT_TIMEOUT_EN - abort a beat with err when the slave    |
// |               stays silent for TIMEOUT cycles. TOW is the width of the      |
// |               timeout counter.                                              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

package wb_split128to32_pkg;

    // Access size encoding carried in the sz field.
    localparam logic [2:0] c_SZ_BYTE  = 3'd0;
    localparam logic [2:0] c_SZ_WYDE  = 3'd1;
    localparam logic [2:0] c_SZ_TETRA = 3'd2;
    localparam logic [2:0] c_SZ_OCTA  = 3'd3;
    localparam logic [2:0] c_SZ_HEXI  = 3'd4;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [4:0]   cmd;
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic [2:0]   sz;
        logic [7:0]   attr;
        logic [15:0]  sel;
        logic [31:0]  padr;
        logic [31:0]  vadr;
        logic [127:0] data1;
    } wb_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic         stall;
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic [127:0] dat;
    } wb_cmd_response128_t;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [4:0]   cmd;
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic [2:0]   sz;
        logic [7:0]   attr;
        logic [3:0]   sel;
        logic [31:0]  padr;
        logic [31:0]  vadr;
        logic [31:0]  dat;
    } wb_cmd_request32_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic [31:0]  dat;
    } wb_cmd_response32_t;

endpackage : wb_split128to32_pkg

module wb_split128to32
    import wb_split128to32_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  wb_cmd_request128_t  req128_i,
    output wb_cmd_response128_t resp128_o,
    output wb_cmd_request32_t   req32_o,
    input  wb_cmd_response32_t  resp32_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The timeout counter must be able to hold TIMEOUT-1 and at least one
    // silent cycle has to be allowed.
    if (TIMEOUT < 1 || TIMEOUT >= (2 ** TOW)) begin : g_bad_timeout
        $error("wb_split128to32: TIMEOUT must satisfy 1 <= TIMEOUT < 2**TOW");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // One bit per 32-bit lane: set when any byte of that lane is selected.
    function automatic logic [3:0] lanes_of(input logic [15:0] sel);
        logic [3:0] m;
        for (int k = 0; k < 4; k++) begin
            m[k] = |sel[4*k +: 4];
        end
        return m;
    endfunction

    // Index of the lowest set bit. Callers only use it on a non-zero mask.
    function automatic logic [1:0] first_lane(input logic [3:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (m[k]) begin
                l = 2'(k);
            end
        end
        return l;
    endfunction

    // Downstream beat for one lane of the latched request.
    function automatic wb_cmd_request32_t beat_of(input wb_cmd_request128_t r,
                                                  input logic [1:0]         lane);
        wb_cmd_request32_t b;
        b      = '0;
        // The latched copy was only taken with cyc and stb high.
        b.cyc  = r.cyc;
        b.stb  = r.stb;
        b.we   = r.we;
        b.cmd  = r.cmd;
        b.cid  = r.cid;
        b.tid  = r.tid;
        b.attr = r.attr;
        b.sel  = r.sel[{lane, 2'b00} +: 4];
        b.padr = {r.padr[31:4], lane, 2'b00};
        b.vadr = {r.vadr[31:4], lane, 2'b00};
        b.dat  = r.data1[{lane, 5'b00000} +: 32];
        // A fully selected lane is a plain word access whatever the
        // original size was; partial lanes keep the requested size.
        b.sz   = (b.sel == 4'hF) ? c_SZ_TETRA : r.sz;
        return b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [1:0]          lane_q,  lane_d;
    logic [3:0]          mask_q,  mask_d;   // lanes still to be issued
    logic [127:0]        buf_q,   buf_d;    // read data reassembly buffer
    wb_cmd_request128_t  req_q,   req_d;    // latched upstream request
    wb_cmd_request32_t   req32_q, req32_d;
    wb_cmd_response128_t resp_q,  resp_d;

    logic                fl_ack;
    logic                fl_err;
    logic                fl_rty;
    logic [3:0]          rem_mask;

`ifdef WB_SPLIT_TIMEOUT_EN
    logic [TOW-1:0]      tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        mask_d   = mask_q;
        buf_d    = buf_q;
        req_d    = req_q;
        fl_ack   = 1'b0;
        fl_err   = 1'b0;
        fl_rty   = 1'b0;
        rem_mask = 4'b0000;
`ifdef WB_SPLIT_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req128_i.cyc && req128_i.stb) begin
                    req_d  = req128_i;
                    mask_d = lanes_of(req128_i.sel);
                    buf_d  = '0;
`ifdef WB_SPLIT_TIMEOUT_EN
                    tmo_d  = '0;
`endif
                    if (mask_d != 4'b0000) begin
                        lane_d  = first_lane(mask_d);
                        state_d = ST_BEAT;
                    end else begin
                        // Nothing selected: answer without touching the bus.
                        state_d = ST_DONE;
                        fl_ack  = 1'b1;
                    end
                end
            end

            ST_BEAT: begin
                // err beats rty beats ack when several flags arrive together.
                if (resp32_i.err) begin
                    mask_d  = 4'b0000;
                    state_d = ST_DONE;
                    fl_err  = 1'b1;
                end else if (resp32_i.rty) begin
                    mask_d  = 4'b0000;
                    state_d = ST_DONE;
                    fl_rty  = 1'b1;
                end else if (resp32_i.ack) begin
                    if (!req_q.we) begin
                        buf_d[{lane_q, 5'b00000} +: 32] = resp32_i.dat;
                    end
                    rem_mask = mask_q & ~(4'b0001 << lane_q);
                    mask_d   = rem_mask;
`ifdef WB_SPLIT_TIMEOUT_EN
                    tmo_d    = '0;
`endif
                    if (rem_mask != 4'b0000) begin
                        lane_d = first_lane(rem_mask);
                    end else begin
                        state_d = ST_DONE;
                        fl_ack  = 1'b1;
                    end
                end
`ifdef WB_SPLIT_TIMEOUT_EN
                // The TIMEOUT-th silent cycle ends the beat as a slave err.
                else if (tmo_q == TOW'(TIMEOUT - 1)) begin
                    mask_d  = 4'b0000;
                    state_d = ST_DONE;
                    fl_err  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so that they are
        // registered together with it.
        req32_d = '0;
        if (state_d == ST_BEAT) begin
            req32_d = beat_of(req_d, lane_d);
        end

        resp_d       = '0;
        resp_d.stall = (state_d != ST_IDLE);
        resp_d.ack   = fl_ack;
        resp_d.err   = fl_err;
        resp_d.rty   = fl_rty;
        resp_d.cid   = req_d.cid;
        resp_d.tid   = req_d.tid;
        if (state_d == ST_DONE && !req_d.we) begin
            resp_d.dat = buf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            lane_q  <= 2'd0;
            mask_q  <= 4'b0000;
            buf_q   <= '0;
            req_q   <= '0;
            req32_q <= '0;
            resp_q  <= '0;
`ifdef WB_SPLIT_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mask_q  <= mask_d;
            buf_q   <= buf_d;
            req_q   <= req_d;
            req32_q <= req32_d;
            resp_q  <= resp_d;
`ifdef WB_SPLIT_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign req32_o   = req32_q;
    assign resp128_o = resp_q;

endmodule : wb_split128to32

`default_nettype wire

// File: tb/tb_wb_split128to32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_split128to32                                           |
// | Description : Self-checking bench for wb_split128to32. A scripted slave    |
// |               answers each 32-bit beat after a chosen latency (optionally  |
// |               with err/rty); expected beats, response flags, data and      |
// |               latency come from a lane-list model of the request.          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_wb_split128to32;
    import wb_split128to32_pkg::*;

`ifdef WB_SPLIT_TIMEOUT_EN
    localparam int c_TIMEOUT = 8;
`else
    localparam int c_TIMEOUT = 255;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    wb_cmd_request128_t  req128;
    wb_cmd_response128_t resp128;
    wb_cmd_request32_t   req32;
    wb_cmd_response32_t  resp32;

    wb_split128to32 #(
        .TIMEOUT (c_TIMEOUT),
        .TOW     (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req128_i  (req128),
        .resp128_o (resp128),
        .req32_o   (req32),
        .resp32_i  (resp32)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc_cnt  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scripted slave
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] padr;
        logic [31:0] vadr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [2:0]  sz;
        logic        we;
    } beat_t;

    beat_t       got_q[$];
    int          slv_lat;
    int          slv_err_b;
    int          slv_rty_b;
    bit          slv_both;
    bit          slv_silent;
    bit          slv_stray;
    int          slv_cnt;
    int          slv_idx;
    logic [31:0] slv_rd[4];

    initial begin
        beat_t b;
        resp32     = '0;
        slv_lat    = 0;
        slv_err_b  = -1;
        slv_rty_b  = -1;
        slv_both   = 0;
        slv_silent = 0;
        slv_stray  = 0;
        slv_cnt    = 0;
        slv_idx    = 0;
        forever begin
            @(negedge clk);
            if (resp32.ack || resp32.err || resp32.rty) begin
                resp32  = '0;
                slv_cnt = 0;
            end
            if (slv_stray) begin
                resp32.ack = 1'b1;
                slv_stray  = 0;
            end else if (rst_n && req32.cyc && req32.stb && !slv_silent) begin
                slv_cnt++;
                if (slv_cnt > slv_lat) begin
                    b.padr = req32.padr;
                    b.vadr = req32.vadr;
                    b.sel  = req32.sel;
                    b.dat  = req32.dat;
                    b.sz   = req32.sz;
                    b.we   = req32.we;
                    got_q.push_back(b);
                    resp32.dat = (slv_idx < 4) ? slv_rd[slv_idx] : 32'hDEAD_0000;
                    if (slv_idx == slv_err_b) begin
                        resp32.err = 1'b1;
                        resp32.ack = slv_both;
                    end else if (slv_idx == slv_rty_b) begin
                        resp32.rty = 1'b1;
                        resp32.ack = slv_both;
                    end else begin
                        resp32.ack = 1'b1;
                    end
                    slv_idx++;
                    slv_cnt = 0;
                end
            end else begin
                slv_cnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One upstream request, checked against the lane-list model
    // ------------------------------------------------------------------
    task automatic do_req(input string name, input logic we, input logic [15:0] sel,
                          input logic [31:0] padr, input logic [127:0] d1,
                          input int lat, input int err_b, input int rty_b, input bit both);
        int           lanes[$];
        int           fail_idx;
        int           n_exp;
        int           ln;
        logic [2:0]   exp_fl;
        logic [127:0] exp_dat;
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic [2:0]   sz;
        logic [31:0]  vadr;
        logic [3:0]   nib;
        logic [103:0] eb;
        logic [103:0] gb;
        int unsigned  t0;
        bit           got_resp;
        bit           stall_ok;

        for (int k = 0; k < 4; k++) begin
            if (((sel >> (4 * k)) & 16'hF) != 0) lanes.push_back(k);
        end
        fail_idx = lanes.size();
        if (err_b >= 0 && err_b < fail_idx) fail_idx = err_b;
        if (rty_b >= 0 && rty_b < fail_idx) fail_idx = rty_b;
        if (fail_idx == lanes.size()) begin
            n_exp  = lanes.size();
            exp_fl = 3'b001;
        end else begin
            n_exp  = fail_idx + 1;
            exp_fl = (fail_idx == err_b) ? 3'b010 : 3'b100;
        end
        exp_dat = '0;
        if (!we) begin
            for (int i = 0; i < fail_idx; i++) begin
                exp_dat = exp_dat | (128'(slv_rd[i]) << (32 * lanes[i]));
            end
        end

        cid  = 8'($urandom);
        tid  = 8'($urandom);
        sz   = 3'($urandom_range(0, 4));
        vadr = $urandom;

        @(posedge clk);
        #1;
        slv_lat   = lat;
        slv_err_b = err_b;
        slv_rty_b = rty_b;
        slv_both  = both;
        slv_idx   = 0;
        got_q.delete();

        @(negedge clk);
        req128       = '0;
        req128.cyc   = 1'b1;
        req128.stb   = 1'b1;
        req128.we    = we;
        req128.cmd   = 5'($urandom);
        req128.cid   = cid;
        req128.tid   = tid;
        req128.sz    = sz;
        req128.attr  = 8'($urandom);
        req128.sel   = sel;
        req128.padr  = padr;
        req128.vadr  = vadr;
        req128.data1 = d1;
        t0 = cyc_cnt;

        // Accepted at this edge; scramble the bus so only the latched copy is valid.
        @(negedge clk);
        req128.cyc   = 1'b0;
        req128.stb   = 1'b0;
        req128.we    = ~we;
        req128.sel   = ~sel;
        req128.padr  = ~padr;
        req128.vadr  = ~vadr;
        req128.data1 = ~d1;
        req128.cid   = ~cid;
        req128.tid   = ~tid;

        got_resp = 0;
        stall_ok = 1;
        for (int c = 0; c < 200 && !got_resp; c++) begin
            if (!resp128.stall) stall_ok = 0;
            if (resp128.ack || resp128.err || resp128.rty) got_resp = 1;
            else @(negedge clk);
        end
        if (!got_resp) begin
            check({name, " no response"}, 0, 1);
            return;
        end

        check({name, " flags rty/err/ack"}, {resp128.rty, resp128.err, resp128.ack}, exp_fl);
        check({name, " dat"}, resp128.dat, exp_dat);
        check({name, " cid/tid"}, {resp128.cid, resp128.tid}, {cid, tid});
        check({name, " latency"}, cyc_cnt - t0, n_exp * (lat + 1) + 1);
        check({name, " stall while busy"}, stall_ok, 1);
        check({name, " cyc dropped"}, {req32.cyc, req32.stb}, 2'b00);
        check({name, " beat count"}, got_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
            ln  = lanes[i];
            nib = 4'((sel >> (4 * ln)) & 16'hF);
            eb  = {(padr & 32'hFFFF_FFF0) | 32'(ln * 4),
                   (vadr & 32'hFFFF_FFF0) | 32'(ln * 4),
                   nib, 32'(d1 >> (32 * ln)),
                   (nib == 4'hF) ? 3'd2 : sz, we};
            gb  = {got_q[i].padr, got_q[i].vadr, got_q[i].sel, got_q[i].dat,
                   got_q[i].sz, got_q[i].we};
            check($sformatf("%s beat%0d", name, i), gb, eb);
        end

        @(negedge clk);
        check({name, " single response"},
              {resp128.ack, resp128.err, resp128.rty, resp128.stall}, 4'b0000);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int hi_cnt;
        bit bad;
        bit found;
        int unsigned t0;
        logic [15:0] rsel;

        rst_n  = 1'b0;
        req128 = '0;
        for (int i = 0; i < 4; i++) slv_rd[i] = $urandom;
        repeat (3) @(negedge clk);
        check("reset req32", req32, '0);
        check("reset resp128", resp128, '0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("wr_full", 1'b1, 16'hFFFF, 32'h0000_1000,
               128'h33333333_22222222_11111111_00000000, 1, -1, -1, 0);

        slv_rd[0] = 32'hAABBCCDD;
        slv_rd[1] = 32'h11223344;
        do_req("rd_0f0f", 1'b0, 16'h0F0F, 32'h0000_2000,
               {$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 0);

        do_req("wr_0030", 1'b1, 16'h0030, 32'h0000_3000,
               {$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 0);
        do_req("wr_sel0", 1'b1, 16'h0000, 32'h0000_4000,
               {$urandom, $urandom, $urandom, $urandom}, 1, -1, -1, 0);
        do_req("rd_sel0", 1'b0, 16'h0000, 32'h0000_4010,
               {$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 0);
        do_req("wr_err2", 1'b1, 16'hFFFF, 32'h0000_5000,
               {$urandom, $urandom, $urandom, $urandom}, 1, 1, -1, 0);
        do_req("rd_err_ack", 1'b0, 16'hF0F1, 32'h0000_6000,
               {$urandom, $urandom, $urandom, $urandom}, 0, 2, 2, 1);
        do_req("rd_rty_ack", 1'b0, 16'h8421, 32'h0000_7000,
               {$urandom, $urandom, $urandom, $urandom}, 2, -1, 1, 1);

        // Reset during beat 3 of a read.
        for (int i = 0; i < 4; i++) slv_rd[i] = $urandom;
        @(posedge clk);
        #1;
        slv_lat = 1; slv_err_b = -1; slv_rty_b = -1; slv_both = 0; slv_idx = 0;
        @(negedge clk);
        req128      = '0;
        req128.cyc  = 1'b1;
        req128.stb  = 1'b1;
        req128.sel  = 16'hFFFF;
        req128.padr = 32'h0000_8000;
        @(negedge clk);
        req128 = '0;
        found  = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (req32.cyc && req32.padr[3:2] == 2'd2) found = 1;
            else @(negedge clk);
        end
        check("rst beat3 reached", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst cyc/stb drop", {req32.cyc, req32.stb}, 2'b00);
        check("rst no resp", {resp128.ack, resp128.err, resp128.rty}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        slv_stray = 1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp128.ack || resp128.err || resp128.rty || req32.cyc) bad = 1;
        end
        check("late ack ignored", bad, 0);
        do_req("after_rst", 1'b0, 16'h00F0, 32'h0000_9000,
               {$urandom, $urandom, $urandom, $urandom}, 0, -1, -1, 0);

        // Silent slave.
        @(posedge clk);
        #1;
        slv_silent = 1;
        @(negedge clk);
        req128      = '0;
        req128.cyc  = 1'b1;
        req128.stb  = 1'b1;
        req128.we   = 1'b1;
        req128.sel  = 16'h000F;
        req128.padr = 32'h0000_A000;
        t0 = cyc_cnt;
        @(negedge clk);
        req128 = '0;
`ifdef WB_SPLIT_TIMEOUT_EN
        hi_cnt = 0;
        found  = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (resp128.ack || resp128.err || resp128.rty) found = 1;
            else begin
                if (req32.cyc) hi_cnt++;
                @(negedge clk);
            end
        end
        check("tmo response", found, 1);
        check("tmo flags rty/err/ack", {resp128.rty, resp128.err, resp128.ack}, 3'b010);
        check("tmo beat cycles", hi_cnt, c_TIMEOUT);
        check("tmo latency", cyc_cnt - t0, c_TIMEOUT + 1);
        @(negedge clk);
`else
        hi_cnt = 0;
        bad    = 0;
        for (int c = 0; c < 120; c++) begin
            if (req32.cyc && req32.stb) hi_cnt++;
            if (resp128.ack || resp128.err || resp128.rty) bad = 1;
            @(negedge clk);
        end
        check("no tmo cyc held", hi_cnt, 120);
        check("no tmo no resp", bad, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        slv_silent = 0;
        @(negedge clk);

        // Randomized requests.
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0:       rsel = 16'h0000;
                1:       rsel = 16'hFFFF;
                default: rsel = 16'($urandom);
            endcase
            for (int i = 0; i < 4; i++) slv_rd[i] = $urandom;
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), rsel, $urandom,
                   {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                   1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_wb_split128to32

`default_nettype wire
